// File: rtl/split_bus_arbiter_pkg.sv
// Shared types and helpers for the split-capable bus arbiter.
package bus_arb_pkg;

  // Arbiter has two states: nobody owns the bus, or exactly one master does.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  // Arbitration policies selected by the ARB_MODE parameter.
  localparam int FIXED = 0;
  localparam int RR    = 1;

  // Width of the OWNER index: max(1, clog2(n)).
  function automatic int owner_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/split_bus_arbiter_rr_pick.sv
// Rotating-priority picker: returns the one-hot index of the first set
// request at or after 'start', wrapping from N-1 back to 0. A fixed-priority
// picker is the same circuit with start tied to zero.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [N-1:0] grant
);

  logic [N-1:0] cand;

  // Walk from the farthest offset down to start so the nearest request wins.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    grant = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = N'(1) << ((int'(start) + k) % N);
      if (|(req & cand)) grant = cand;
    end
  end

endmodule

// File: rtl/split_bus_arbiter.sv
// Bus arbiter with split-transaction parking and optional lock.
// One master owns the bus at a time; a split parks the owner in SPLIT_MASK
// until the slave signals SPLIT_RESUME for it. A locked owner keeps the bus
// across back-to-back transfers without a turnaround cycle.
// Optional feature: define ARB_TIMEOUT_EN to release an unlocked owner after
// TIMEOUT cycles without XFER_DONE. Without it, tenure is unbounded.
module split_bus_arbiter #(
  parameter int N_MASTERS = 4,
  parameter int ARB_MODE  = 0,
  parameter int TIMEOUT   = 16
) (
  input  logic                                       CLK,
  input  logic                                       RST,
  input  logic [N_MASTERS-1:0]                       REQ,
  input  logic [N_MASTERS-1:0]                       LOCK,
  input  logic                                       XFER_DONE,
  input  logic                                       SPLIT,
  input  logic [N_MASTERS-1:0]                       SPLIT_RESUME,
  output logic [N_MASTERS-1:0]                       GRANT,
  output logic [bus_arb_pkg::owner_w(N_MASTERS)-1:0] OWNER,
  output logic                                       BUSY,
  output logic [N_MASTERS-1:0]                       SPLIT_MASK
);

  import bus_arb_pkg::*;

  localparam int OW = owner_w(N_MASTERS);

  arb_state_e           state;
  logic [N_MASTERS-1:0] grant_q;
  logic [N_MASTERS-1:0] mask_q;
  logic [OW-1:0]        owner_q;
  logic [OW-1:0]        rr_ptr;

  logic [N_MASTERS-1:0] eligible;
  logic [N_MASTERS-1:0] pick;
  logic [N_MASTERS-1:0] mask_set;
  logic [OW-1:0]        pick_idx;
  logic [OW-1:0]        ptr_next;
  logic [OW-1:0]        start;
  logic                 owner_lock;
  logic                 owner_req;
  logic                 timed_out;
  logic                 release_bus;

  // Parked masters are invisible to arbitration, even when locked.
  assign eligible = REQ & ~mask_q;
  assign start    = (ARB_MODE == RR) ? rr_ptr : '0;

  rr_pick #(
    .N (N_MASTERS),
    .W (OW)
  ) u_pick (
    .req   (eligible),
    .start (start),
    .grant (pick)
  );

  // Encode the one-hot winner into an index for OWNER and the pointer.
  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (pick[k]) pick_idx = OW'(k);
    end
  end

  assign ptr_next = (pick_idx == OW'(N_MASTERS - 1)) ? '0 : pick_idx + 1'b1;

  // The one-hot grant doubles as a selector for the owner's LOCK/REQ bits.
  assign owner_lock = |(LOCK & grant_q);
  assign owner_req  = |(REQ & grant_q);

  // A split only parks someone while the bus is actually owned.
  assign mask_set = (state == ST_OWN && SPLIT) ? grant_q : '0;

  // Split beats done; a locked, still-requesting owner survives done.
  assign release_bus = SPLIT
                    || (XFER_DONE && !(owner_lock && owner_req))
                    || timed_out;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tenure;

  assign timed_out = !owner_lock && (tenure == TW'(TIMEOUT - 1));

  // Count consecutive unlocked owned cycles without a completed transfer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tenure <= '0;
    end else if (state != ST_OWN || XFER_DONE || SPLIT || owner_lock || timed_out) begin
      tenure <= '0;
    end else begin
      tenure <= tenure + 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  // Ownership FSM, grant/owner registers, split parking and RR pointer.
  always_ff @(posedge CLK) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (RST) begin
      state   <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      rr_ptr  <= '0;
      mask_q  <= '0;
    end else begin
      // Setting a bit wins over a resume for that bit in the same cycle.
      mask_q <= (mask_q & ~SPLIT_RESUME) | mask_set;
      case (state)
        ST_IDLE: begin
          if (|eligible) begin
            state   <= ST_OWN;
            grant_q <= pick;
            owner_q <= pick_idx;
            if (ARB_MODE == RR) rr_ptr <= ptr_next;
          end
        end
        ST_OWN: begin
          if (release_bus) begin
            state   <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign GRANT      = grant_q;
  assign OWNER      = owner_q;
  assign BUSY       = |grant_q;
  assign SPLIT_MASK = mask_q;

endmodule

// File: tb/tb_split_bus_arbiter.sv
// Self-checking bench for split_bus_arbiter with N_MASTERS=4: one fixed
// priority and one round-robin instance share the same stimulus and are
// compared every cycle against a behavioural model.
module tb_split_bus_arbiter;

  localparam int TMO = 16;

  logic       CLK;
  logic       RST;
  logic [3:0] REQ;
  logic [3:0] LOCK;
  logic       XFER_DONE;
  logic       SPLIT;
  logic [3:0] SPLIT_RESUME;

  logic [3:0] g_f, m_f, g_r, m_r;
  logic [1:0] o_f, o_r;
  logic       b_f, b_r;

  int n_tests = 0;
  int n_fail  = 0;

  split_bus_arbiter #(.N_MASTERS(4), .ARB_MODE(0), .TIMEOUT(TMO)) dut_fixed (
    .CLK(CLK), .RST(RST), .REQ(REQ), .LOCK(LOCK), .XFER_DONE(XFER_DONE),
    .SPLIT(SPLIT), .SPLIT_RESUME(SPLIT_RESUME),
    .GRANT(g_f), .OWNER(o_f), .BUSY(b_f), .SPLIT_MASK(m_f)
  );

  split_bus_arbiter #(.N_MASTERS(4), .ARB_MODE(1), .TIMEOUT(TMO)) dut_rr (
    .CLK(CLK), .RST(RST), .REQ(REQ), .LOCK(LOCK), .XFER_DONE(XFER_DONE),
    .SPLIT(SPLIT), .SPLIT_RESUME(SPLIT_RESUME),
    .GRANT(g_r), .OWNER(o_r), .BUSY(b_r), .SPLIT_MASK(m_r)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural model, index 0 = fixed priority, 1 = round robin.
  // Owner -1 means the bus is idle.
  int         m_owner[2];
  logic [3:0] m_mask[2];
  int         m_ptr[2];
  int         m_ten[2];

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] lock;
    logic       done;
    logic       split;
    logic [3:0] resume;
    logic [3:0] exp_grant;
    logic [1:0] exp_owner;
    logic [3:0] exp_mask;
  } vec_t;

  vec_t vq[$];
  int   rr_order[5] = '{0, 1, 2, 3, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_step(input int m);
    logic [3:0] elig;
    int         start;
    int         idx;
    int         o;
    idx = 0;
    if (RST) begin
      m_owner[m] = -1;
      m_mask[m]  = 4'b0;
      m_ptr[m]   = 0;
      m_ten[m]   = 0;
      return;
    end
    if (m_owner[m] < 0) begin
      elig      = REQ & ~m_mask[m];
      m_mask[m] = m_mask[m] & ~SPLIT_RESUME;
      if (elig != 4'b0) begin
        start = (m == 1) ? m_ptr[m] : 0;
        for (int k = 0; k < 4; k++) begin
          idx = (start + k) % 4;
          if (elig[idx]) break;
        end
        m_owner[m] = idx;
        if (m == 1) m_ptr[m] = (idx + 1) % 4;
        m_ten[m] = 0;
      end
    end else begin
      o = m_owner[m];
      if (SPLIT) begin
        m_mask[m]  = (m_mask[m] & ~SPLIT_RESUME) | 4'(1 << o);
        m_owner[m] = -1;
        m_ten[m]   = 0;
      end else begin
        m_mask[m] = m_mask[m] & ~SPLIT_RESUME;
        if (XFER_DONE) begin
          if (!(LOCK[o] && REQ[o])) m_owner[m] = -1;
          m_ten[m] = 0;
        end else begin
`ifdef ARB_TIMEOUT_EN
          if (LOCK[o]) begin
            m_ten[m] = 0;
          end else begin
            m_ten[m]++;
            if (m_ten[m] == TMO) begin
              m_owner[m] = -1;
              m_ten[m]   = 0;
            end
          end
`endif
        end
      end
    end
  endtask

  function automatic logic [3:0] exp_grant(input int m);
    return (m_owner[m] < 0) ? 4'b0 : 4'(1 << m_owner[m]);
  endfunction

  function automatic logic [1:0] exp_owner(input int m);
    return (m_owner[m] < 0) ? 2'd0 : 2'(m_owner[m]);
  endfunction

  task automatic compare_model();
    check("fixed grant", g_f, exp_grant(0));
    check("fixed owner", o_f, exp_owner(0));
    check("fixed busy",  b_f, m_owner[0] >= 0);
    check("fixed mask",  m_f, m_mask[0]);
    check("rr grant",    g_r, exp_grant(1));
    check("rr owner",    o_r, exp_owner(1));
    check("rr busy",     b_r, m_owner[1] >= 0);
    check("rr mask",     m_r, m_mask[1]);
  endtask

  // Advance one clock with the inputs currently driven, then compare.
  task automatic cycle();
    model_step(0);
    model_step(1);
    @(posedge CLK);
    #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    RST = 1'b0; REQ = 4'b0; LOCK = 4'b0;
    XFER_DONE = 1'b0; SPLIT = 1'b0; SPLIT_RESUME = 4'b0;
  endtask

  task automatic add_vec(input logic rst, input logic [3:0] req, input logic [3:0] lock,
                         input logic done, input logic split, input logic [3:0] resume,
                         input logic [3:0] eg, input logic [1:0] eo, input logic [3:0] em);
    vec_t v;
    v.rst = rst; v.req = req; v.lock = lock; v.done = done; v.split = split;
    v.resume = resume; v.exp_grant = eg; v.exp_owner = eo; v.exp_mask = em;
    vq.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int held;
    int waited;
    for (int m = 0; m < 2; m++) begin
      m_owner[m] = -1; m_mask[m] = 4'b0; m_ptr[m] = 0; m_ten[m] = 0;
    end
    idle_inputs();
    RST = 1'b1;

    // Directed vectors for the fixed-priority instance: expected values are
    // the outputs after the edge that samples the row's inputs.
    //       rst   req    lock   done  split resume  grant  own   mask
    add_vec(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'b0000, 2'd0, 4'b0000); // reset
    add_vec(1'b0, 4'h6, 4'h0, 1'b0, 1'b0, 4'h0, 4'b0010, 2'd1, 4'b0000); // lowest wins
    add_vec(1'b0, 4'h4, 4'h0, 1'b1, 1'b0, 4'h0, 4'b0000, 2'd0, 4'b0000); // turnaround
    add_vec(1'b0, 4'h4, 4'h0, 1'b0, 1'b0, 4'h0, 4'b0100, 2'd2, 4'b0000); // next master
    add_vec(1'b0, 4'h5, 4'h4, 1'b1, 1'b0, 4'h0, 4'b0100, 2'd2, 4'b0000); // locked keep
    add_vec(1'b0, 4'h5, 4'h4, 1'b0, 1'b0, 4'h0, 4'b0100, 2'd2, 4'b0000);
    add_vec(1'b0, 4'h5, 4'h0, 1'b0, 1'b0, 4'h0, 4'b0100, 2'd2, 4'b0000); // lock dropped
    add_vec(1'b0, 4'h5, 4'h0, 1'b1, 1'b0, 4'h0, 4'b0000, 2'd0, 4'b0000); // released
    add_vec(1'b0, 4'h5, 4'h0, 1'b0, 1'b0, 4'h0, 4'b0001, 2'd0, 4'b0000); // master 0 wins
    add_vec(1'b0, 4'h3, 4'h0, 1'b0, 1'b1, 4'h0, 4'b0000, 2'd0, 4'b0001); // split parks 0
    add_vec(1'b0, 4'h3, 4'h0, 1'b0, 1'b0, 4'h0, 4'b0010, 2'd1, 4'b0001); // 1 granted
    add_vec(1'b0, 4'h3, 4'h0, 1'b0, 1'b0, 4'h1, 4'b0010, 2'd1, 4'b0000); // resume 0
    add_vec(1'b0, 4'h3, 4'h0, 1'b1, 1'b0, 4'h0, 4'b0000, 2'd0, 4'b0000); // 1 finishes
    add_vec(1'b0, 4'h1, 4'h0, 1'b0, 1'b0, 4'h0, 4'b0001, 2'd0, 4'b0000); // 0 re-granted
    add_vec(1'b0, 4'h1, 4'h0, 1'b1, 1'b1, 4'h0, 4'b0000, 2'd0, 4'b0001); // split+done
    add_vec(1'b0, 4'h1, 4'h1, 1'b0, 1'b0, 4'h0, 4'b0000, 2'd0, 4'b0001); // masked+locked
    add_vec(1'b0, 4'h1, 4'h0, 1'b0, 1'b0, 4'h1, 4'b0000, 2'd0, 4'b0000); // resume only
    add_vec(1'b0, 4'h1, 4'h0, 1'b0, 1'b0, 4'h0, 4'b0001, 2'd0, 4'b0000);
    add_vec(1'b0, 4'h1, 4'h0, 1'b0, 1'b1, 4'h1, 4'b0000, 2'd0, 4'b0001); // set beats resume
    add_vec(1'b0, 4'h2, 4'h0, 1'b0, 1'b0, 4'h1, 4'b0010, 2'd1, 4'b0000);
    add_vec(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 4'b0000, 2'd0, 4'b0000);
    add_vec(1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 4'b0000, 2'd0, 4'b0000); // ignored idle
    add_vec(1'b0, 4'h4, 4'h0, 1'b0, 1'b0, 4'h0, 4'b0100, 2'd2, 4'b0000);
    add_vec(1'b1, 4'h4, 4'h4, 1'b0, 1'b0, 4'h0, 4'b0000, 2'd0, 4'b0000); // reset mid-own
    add_vec(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'b0000, 2'd0, 4'b0000);

    for (int i = 0; i < vq.size(); i++) begin
      RST = vq[i].rst; REQ = vq[i].req; LOCK = vq[i].lock;
      XFER_DONE = vq[i].done; SPLIT = vq[i].split; SPLIT_RESUME = vq[i].resume;
      cycle();
      check($sformatf("vec%0d grant", i), g_f, vq[i].exp_grant);
      check($sformatf("vec%0d owner", i), o_f, vq[i].exp_owner);
      check($sformatf("vec%0d busy", i),  b_f, |vq[i].exp_grant);
      check($sformatf("vec%0d mask", i),  m_f, vq[i].exp_mask);
    end

    // Round-robin order with all masters requesting continuously.
    idle_inputs();
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    REQ = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      waited = 0;
      while (g_r == 4'b0 && waited < 4) begin
        cycle();
        waited++;
      end
      check($sformatf("rr order %0d busy", t), b_r, 1'b1);
      check($sformatf("rr order %0d owner", t), o_r, rr_order[t]);
      XFER_DONE = 1'b1;
      cycle();
      XFER_DONE = 1'b0;
    end

    // Tenure of an unlocked owner that never completes.
    idle_inputs();
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    REQ = 4'b0001;
    cycle();
    held = 0;
    while (g_f != 4'b0 && held < 40) begin
      cycle();
      held++;
    end
`ifdef ARB_TIMEOUT_EN
    check("timeout tenure", held, TMO);
`else
    check("unbounded tenure", held, 40);
`endif

    // Randomized traffic against the model.
    idle_inputs();
    RST = 1'b1;
    cycle();
    for (int i = 0; i < 3000; i++) begin
      RST          = ($urandom_range(0, 63) == 0);
      REQ          = 4'($urandom);
      LOCK         = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      XFER_DONE    = ($urandom_range(0, 3) == 0);
      SPLIT        = ($urandom_range(0, 9) == 0);
      SPLIT_RESUME = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/split_bus_arbiter.md
SPLIT_BUS_ARBITER -- requirements
Module: split_bus_arbiter

Interface
REQ-001 The block SHALL have parameter N_MASTERS, default 4, the number of requesting masters (2..16).
REQ-002 The block SHALL have parameter ARB_MODE, default 0, where 0 is fixed priority (lowest index wins) and 1 is round-robin.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, the maximum tenure in cycles of an unlocked owner (used only under REQ-027).
REQ-004 The block SHALL have port CLK, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have port REQ, input, N_MASTERS bits, per-master bus request.
REQ-007 The block SHALL have port LOCK, input, N_MASTERS bits, per-master lock (keep ownership across transfers).
REQ-008 The block SHALL have port XFER_DONE, input, 1 bit, the current owner's transfer completed this cycle.
REQ-009 The block SHALL have port SPLIT, input, 1 bit, the addressed slave splits the current owner's transfer.
REQ-010 The block SHALL have port SPLIT_RESUME, input, N_MASTERS bits, the slave is ready to resume master i.
REQ-011 The block SHALL have port GRANT, output, N_MASTERS bits, one-hot or zero bus grant.
REQ-012 The block SHALL have port OWNER, output, max(1,clog2(N_MASTERS)) bits, the index of the granted master (0 when idle).
REQ-013 The block SHALL have port BUSY, output, 1 bit, asserted while any GRANT bit is set.
REQ-014 The block SHALL have port SPLIT_MASK, output, N_MASTERS bits, the masters currently parked by split.

Function
REQ-015 The block SHALL implement states IDLE and OWN.
REQ-016 In IDLE, with eligible = REQ & ~SPLIT_MASK nonzero, the block SHALL select a winner and register it, so that GRANT is one-hot and the state is OWN on the next cycle (1-cycle latency).
REQ-017 Selection SHALL be: ARB_MODE=0, the lowest set index of eligible; ARB_MODE=1, the first set index at or after the rotation pointer, wrapping N_MASTERS-1 to 0.
REQ-018 In ARB_MODE=1, the rotation pointer SHALL become (winner+1) mod N_MASTERS on every grant.
REQ-019 In OWN, GRANT and OWNER SHALL be held stable until XFER_DONE or SPLIT.
REQ-020 On XFER_DONE with LOCK[owner] and REQ[owner] both 1, the block SHALL keep the same grant with no idle cycle; otherwise GRANT SHALL go to 0 and the state to IDLE for at least one turnaround cycle.
REQ-021 On SPLIT in OWN, the block SHALL set SPLIT_MASK[owner], clear GRANT, and go to IDLE.
REQ-022 SPLIT and XFER_DONE in the same cycle SHALL be treated as SPLIT.
REQ-023 SPLIT_RESUME[i] SHALL clear SPLIT_MASK[i] on the next edge; if set and resume hit the same bit in the same cycle, set SHALL win.
REQ-024 A masked master SHALL never be granted, even if LOCK is set.
REQ-025 SPLIT or XFER_DONE received in IDLE SHALL be ignored.

Reset
REQ-026 On RST, the block SHALL set GRANT=0, OWNER=0, BUSY=0, SPLIT_MASK=0, state=IDLE, rotation pointer=0 and tenure counter=0 at the next edge, overriding all other inputs, including mid-tenure.

Configuration
REQ-027 With ARB_TIMEOUT_EN defined, an owner with LOCK[owner]=0 held for TIMEOUT cycles without XFER_DONE SHALL be released to IDLE as in REQ-020; without the macro, no tenure counter SHALL exist and tenure SHALL be unbounded.

Structure
REQ-028 The package bus_arb_pkg SHALL hold the state enum, the ARB_MODE constants (FIXED, RR) and the OWNER width function.
REQ-029 The sub-module rr_pick SHALL be a combinational rotating-priority select (request vector and start index in, one-hot winner out) and SHALL be used for both modes (start=0 when fixed).

Verification (N_MASTERS=4)
REQ-030 Fixed mode, REQ=4'b0110 in IDLE: GRANT=4'b0010, OWNER=1 one cycle later; XFER_DONE gives GRANT=0 for one cycle, then GRANT=4'b0100.
REQ-031 RR mode, REQ=4'b1111 held, XFER_DONE at every tenure: grant order 0,1,2,3,0.
REQ-032 LOCK[2]=1, REQ=4'b0101, master 2 owning: XFER_DONE keeps GRANT=4'b0100 with no gap; dropping LOCK[2] releases after the next XFER_DONE and master 0 wins.
REQ-033 Master 0 owning, SPLIT=1: SPLIT_MASK=4'b0001, master 1 (REQ=4'b0011) is granted; SPLIT_RESUME=4'b0001 clears the mask; master 0 is re-granted after master 1 finishes.
REQ-034 SPLIT and XFER_DONE together gives mask set; RST pulsed mid-OWN gives all outputs 0 on the next cycle; with ARB_TIMEOUT_EN, TIMEOUT=16 and no XFER_DONE, GRANT drops exactly 16 cycles after grant.
